// File: rtl/omsp_spm_key_writer.sv
// ============================================================================
// Module   : omsp_spm_key_writer
// Brief    : Streams a module key, one 16-bit word per handshake, into SPM control.
//            Optional macro SPM_KEY_ZERO_CHECK_EN adds an all-zero key check.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef SECURITY
`define SECURITY 64
`endif

module omsp_spm_key_writer #(
    parameter int KEY_WORDS    = `SECURITY/16,
    parameter int KEY_IDX_SIZE = $clog2(`SECURITY/16+1)
) (
    input  logic                    mclk,
    input  logic                    puc_rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    src_valid,
    input  logic [15:0]             src_data,
    output logic                    src_ready,
    output logic                    write_key,
    output logic [15:0]             key_in,
    output logic [KEY_IDX_SIZE-1:0] key_idx,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [KEY_IDX_SIZE-1:0] LAST_IDX = KEY_IDX_SIZE'(KEY_WORDS - 1);
    localparam logic [KEY_IDX_SIZE-1:0] IDX_ONE  = KEY_IDX_SIZE'(1);

    state_t                  state;
    logic [KEY_IDX_SIZE-1:0] word_cnt;
    logic                    handshake;

`ifdef SPM_KEY_ZERO_CHECK_EN
    logic [15:0]             key_acc;
`endif

    // Abort masks ready so an abort cycle can never also accept a word.
    assign src_ready = (state == LOAD) & ~abort;
    assign handshake = src_valid & src_ready;
    assign busy      = (state != IDLE);

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            state     <= IDLE;
            word_cnt  <= '0;
            write_key <= 1'b0;
            key_in    <= '0;
            key_idx   <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
`ifdef SPM_KEY_ZERO_CHECK_EN
            key_acc   <= '0;
`endif
        end else begin
            write_key <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state    <= LOAD;
                        word_cnt <= '0;
`ifdef SPM_KEY_ZERO_CHECK_EN
                        key_acc  <= '0;
`endif
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state <= IDLE;
                        error <= 1'b1;
                    end else if (handshake) begin
                        write_key <= 1'b1;
                        key_in    <= src_data;
                        key_idx   <= word_cnt;
`ifdef SPM_KEY_ZERO_CHECK_EN
                        key_acc   <= key_acc | src_data;
`endif
                        // Counter stops at the last index; it never wraps.
                        if (word_cnt == LAST_IDX) begin
                            state <= FINISH;
                        end else begin
                            word_cnt <= word_cnt + IDX_ONE;
                        end
                    end
                end
                FINISH: begin
                    state <= IDLE;
`ifdef SPM_KEY_ZERO_CHECK_EN
                    if (key_acc == 16'h0000) begin
                        error <= 1'b1;
                    end else begin
                        done  <= 1'b1;
                    end
`else
                    done  <= 1'b1;
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
